inst_dec_stage: RTL
===================

// Module: inst_dec_stage
// PURPOSE
//  Registered RV32/RV64 instruction-decode stage with valid/ready handshake on both sides.
//  Splits the instruction into its fields and generates the sign-extended immediate for all base formats.
//  Classifies the format and flags illegal encodings.
//  Sits between instruction fetch and register read/execute. A 2-entry skid (output reg + skid reg) gives full throughput under backpressure.
// PARAMETERS
//  XLEN  32  immediate width; 32 or 64; immediates sign-extended from bit 31 of the instruction
//  PC_W  32  width of the pc carried alongside the instruction
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  flush      in   1      drop all buffered and in-flight instructions (synchronous)
//  in_valid   in   1      upstream instruction valid
//  in_ready   out  1      stage can accept; transfer when in_valid&&in_ready
//  in_inst    in   32     raw instruction word
//  in_pc      in   PC_W   pc of in_inst
//  out_valid  out  1      decoded bundle valid
//  out_ready  in   1      downstream accepts; transfer when out_valid&&out_ready
//  out_pc     out  PC_W   pc of decoded instruction
//  opcode     out  7      inst[6:0]
//  rd         out  5      inst[11:7]
//  funct3     out  3      inst[14:12]
//  rs1        out  5      inst[19:15]
//  rs2        out  5      inst[24:20]
//  funct7     out  7      inst[31:25]
//  imm        out  XLEN   sign-extended immediate; 0 for R-type/illegal
//  fmt        out  3      0=R 1=I 2=S 3=B 4=U 5=J
//  rd_we      out  1      writes rd: fmt in {R,I,U,J}, rd!=0, !illegal
//  rs1_used   out  1      fmt in {R,I,S,B} and !illegal
//  rs2_used   out  1      fmt in {R,S,B} and !illegal
//  illegal    out  1      inst[1:0]!=2'b11 or opcode not in table below
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, in_ready=1, all data outputs 0.
//  - Opcode table: 0110011->R; 0010011,0000011,1100111,0001111,1110011->I; 0100011->S;
//    1100011->B; 0110111,0010111->U; 1101111->J. Any other opcode -> illegal=1, fmt=R, imm=0.
//    Fields are still passed through.
//  - Immediates: I={inst[31:20]}, S={inst[31:25],inst[11:7]}, B={inst[31],inst[7],inst[30:25],inst[11:8],0},
//    U={inst[31:12],12'b0}, J={inst[31],inst[19:12],inst[20],inst[30:21],0}. All sign-extended from inst[31] to XLEN.
//  - Latency: exactly 1 cycle from accept to out_valid when the output register is empty or draining.
//  - Output register loads when it is empty or out_ready=1. Its source is the skid entry if the skid is full,
//    otherwise the input.
//  - If the output register holds valid data with out_ready=0 and input fires: the decoded input goes to the skid.
//  - in_ready = !skid_full (registered). No combinational path from out_ready to in_ready.
//  - Order strictly preserved. Out bundle stays stable while out_valid=1 and out_ready=0.
//  - Simultaneous in-fire and out-fire with skid empty: new bundle replaces old the same edge (no bubble).
//  - flush (or rst) mid-operation: out_valid=0 and skid empty next cycle. The input offered that cycle is discarded.
//    in_ready=1 next cycle. flush has priority over all transfers.
// TESTING
//  1. addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle fmt=1, imm=0xFFFFFFFF, rd=1, rs1=0, rd_we=1, rs2_used=0.
//  2. sw x2,8(x1) (0x0020A423) -> fmt=2, imm=8, rs1=1, rs2=2, rd_we=0.
//     beq x0,x0,-4 (0xFE000EE3) -> fmt=3, imm=0xFFFFFFFC.
//  3. jal x1,+2048 (0x001000EF) -> fmt=5, imm=0x800, rd_we=1.
//     0x00000000 and 0x0000007F -> illegal=1, rd_we=0, imm=0.
//  4. Stream A,B,C with out_ready=0 -> A,B accepted, in_ready=0 after B, C held upstream.
//     Release out_ready -> A,B,C emitted in order on consecutive cycles.
//  5. Output and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     Nothing from before the flush is ever emitted.
//  6. XLEN=64: addi x1,x0,-1 -> imm=0xFFFFFFFFFFFFFFFF. lui x5,0x80000 -> imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/inst_dec_stage_if.sv
// Decode-stage handshake bundle: fetch-side input channel and decoded output channel.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface inst_dec_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7,
               imm, fmt, rd_we, rs1_used, rs2_used, illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7,
               imm, fmt, rd_we, rs1_used, rs2_used, illegal
    );
endinterface

// File: rtl/inst_dec_stage.sv
// RV32/RV64 decode stage: 1-cycle registered decode, output reg + skid reg.
// Full throughput under backpressure; in_ready depends only on skid occupancy.
module inst_dec_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    inst_dec_stage_if.slave  bus
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
        FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } dec_t;

    logic [31:0] w_inst;
    fmt_e        w_fmt;
    logic        w_illegal;
    logic [31:0] w_imm32;
    dec_t        w_dec;
    logic        w_in_fire;
    logic        w_out_load;

    dec_t r_out;
    dec_t r_skid;
    logic r_out_vld;
    logic r_skid_vld;

    assign w_inst = bus.in_inst;

    always_comb begin
        w_fmt     = FMT_R;
        w_illegal = 1'b0;
        w_imm32   = '0;
        case (w_inst[6:0])
            7'b0110011:                         w_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b0001111, 7'b1110011:             w_fmt = FMT_I;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
            default:                            w_illegal = 1'b1;
        endcase
        // Illegal encodings fall through as FMT_R, which carries a zero immediate.
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            FMT_S:   w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            FMT_B:   w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                                w_inst[11:8], 1'b0};
            FMT_U:   w_imm32 = {w_inst[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                                w_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase

        w_dec          = '0;
        w_dec.pc       = bus.in_pc;
        w_dec.inst     = w_inst;
        w_dec.imm      = XLEN'($signed(w_imm32));
        w_dec.fmt      = w_fmt;
        w_dec.illegal  = w_illegal;
        w_dec.rd_we    = !w_illegal && (|w_inst[11:7]) &&
                         (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J});
        w_dec.rs1_used = !w_illegal && (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
        w_dec.rs2_used = !w_illegal && (w_fmt inside {FMT_R, FMT_S, FMT_B});
    end

    assign w_in_fire  = bus.in_valid && !r_skid_vld;
    assign w_out_load = !r_out_vld || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_skid     <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_out_load) begin
            // A full skid blocks the input, so draining it never races a new accept.
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_in_fire) begin
                r_out     <= w_dec;
                r_out_vld <= 1'b1;
            end else begin
                r_out_vld <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid     <= w_dec;
            r_skid_vld <= 1'b1;
        end
    end

    assign bus.in_ready  = !r_skid_vld;
    assign bus.out_valid = r_out_vld;
    assign bus.out_pc    = r_out.pc;
    assign bus.opcode    = r_out.inst[6:0];
    assign bus.rd        = r_out.inst[11:7];
    assign bus.funct3    = r_out.inst[14:12];
    assign bus.rs1       = r_out.inst[19:15];
    assign bus.rs2       = r_out.inst[24:20];
    assign bus.funct7    = r_out.inst[31:25];
    assign bus.imm       = r_out.imm;
    assign bus.fmt       = r_out.fmt;
    assign bus.rd_we     = r_out.rd_we;
    assign bus.rs1_used  = r_out.rs1_used;
    assign bus.rs2_used  = r_out.rs2_used;
    assign bus.illegal   = r_out.illegal;
endmodule
